// File: rtl/hazard_pkg.sv
// Shared types and default latencies for the GPR hazard scoreboard.
// Forwarding selects are meaningful only when SCOREBOARD_FWD_EN is defined.
package hazard_pkg;

    typedef enum logic [1:0] {
        FWD_RF    = 2'd0,
        FWD_EXMEM = 2'd1,
        FWD_MEMWB = 2'd2
    } fwd_sel_e;

    localparam int DEF_NUM_REGS    = 32;
    localparam int DEF_RA_W        = 5;
    localparam int DEF_ALU_LAT     = 1;
    localparam int DEF_LOAD_LAT    = 2;
    localparam int DEF_WB_AGE      = 3;
    localparam int DEF_STALL_CNT_W = 16;

endpackage

// File: rtl/hz_reg_entry.sv
// One GPR's tracking state: cycles until its value is forwardable (wait)
// and cycles since its youngest writer issued, saturating at WB_AGE (age).
module hz_reg_entry
    import hazard_pkg::*;
#(
    parameter int WB_AGE = DEF_WB_AGE,
    parameter int CNT_W  = 2
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             set_i,
    input  logic [CNT_W-1:0] set_wait_i,
    output logic [CNT_W-1:0] wait_o,
    output logic [CNT_W-1:0] age_o
);

    localparam logic [CNT_W-1:0] AGE_MAX = CNT_W'(WB_AGE);

    logic [CNT_W-1:0] wait_q, wait_d;
    logic [CNT_W-1:0] age_q, age_d;

    always_comb begin
        wait_d = (wait_q != '0) ? wait_q - 1'b1 : '0;
        age_d  = (age_q < AGE_MAX) ? age_q + 1'b1 : AGE_MAX;
        // A new writer discards whatever the older one left behind
        if (set_i) begin
            wait_d = set_wait_i;
            age_d  = CNT_W'(1);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wait_q <= '0;
            age_q  <= AGE_MAX;
        end else begin
            wait_q <= wait_d;
            age_q  <= age_d;
        end
    end

    assign wait_o = wait_q;
    assign age_o  = age_q;

endmodule

// File: rtl/hazard_scoreboard.sv
// ID-stage hazard/forwarding unit: per-GPR wait/age tracking, stall, fwd selects.
// Define SCOREBOARD_FWD_EN to enable EX/MEM and MEM/WB forwarding.
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int NUM_REGS    = DEF_NUM_REGS,
    parameter int RA_W        = DEF_RA_W,
    parameter int ALU_LAT     = DEF_ALU_LAT,
    parameter int LOAD_LAT    = DEF_LOAD_LAT,
    parameter int WB_AGE      = DEF_WB_AGE,
    parameter int STALL_CNT_W = DEF_STALL_CNT_W
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   issue_valid,
    input  logic                   issue_wr_en,
    input  logic                   issue_is_load,
    input  logic [RA_W-1:0]        issue_rd,
    input  logic [RA_W-1:0]        src_a,
    input  logic [RA_W-1:0]        src_b,
    input  logic                   use_a,
    input  logic                   use_b,
    input  logic                   flush,
    output logic                   stall,
    output logic                   issue_fire,
    output logic [1:0]             fwd_a,
    output logic [1:0]             fwd_b,
    output logic [STALL_CNT_W-1:0] stall_cnt
);

    localparam int CNT_W = $clog2(WB_AGE + 1);
    localparam logic [CNT_W-1:0] AGE_MAX = CNT_W'(WB_AGE);
`ifdef SCOREBOARD_FWD_EN
    localparam bit FWD_EN = 1'b1;
`else
    localparam bit FWD_EN = 1'b0;
`endif

    logic [CNT_W-1:0] wait_w [NUM_REGS];
    logic [CNT_W-1:0] age_w  [NUM_REGS];
    logic [CNT_W-1:0] set_wait;
    logic             wr_fire;
    logic             haz_a, haz_b;
    fwd_sel_e         sel_a, sel_b;

    logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    // Without forwarding a consumer must wait for the register file write
    assign set_wait = !FWD_EN       ? CNT_W'(WB_AGE - 1)   :
                      issue_is_load ? CNT_W'(LOAD_LAT - 1) :
                                      CNT_W'(ALU_LAT - 1);

    assign wait_w[0] = '0;
    assign age_w[0]  = AGE_MAX;

    for (genvar r = 1; r < NUM_REGS; r++) begin : g_ent
        hz_reg_entry #(
            .WB_AGE (WB_AGE),
            .CNT_W  (CNT_W)
        ) u_ent (
            .clock      (clock),
            .reset_n    (reset_n),
            .set_i      (wr_fire && (issue_rd == RA_W'(r))),
            .set_wait_i (set_wait),
            .wait_o     (wait_w[r]),
            .age_o      (age_w[r])
        );
    end

    assign haz_a = use_a && (src_a != '0) && (wait_w[src_a] != '0);
    assign haz_b = use_b && (src_b != '0) && (wait_w[src_b] != '0);

    assign stall      = reset_n & issue_valid & ~flush & (haz_a | haz_b);
    assign issue_fire = reset_n & issue_valid & ~stall & ~flush;
    assign wr_fire    = issue_fire & issue_wr_en;

    always_comb begin
        sel_a = FWD_RF;
        sel_b = FWD_RF;
        if (FWD_EN && reset_n && use_a && (src_a != '0)
            && (age_w[src_a] < AGE_MAX))
            sel_a = fwd_sel_e'(2'(age_w[src_a]));
        if (FWD_EN && reset_n && use_b && (src_b != '0)
            && (age_w[src_b] < AGE_MAX))
            sel_b = fwd_sel_e'(2'(age_w[src_b]));
    end

    assign fwd_a = sel_a;
    assign fwd_b = sel_b;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall && (stall_cnt_q != '1))
            stall_cnt_d = stall_cnt_q + 1'b1;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            stall_cnt_q <= '0;
        else
            stall_cnt_q <= stall_cnt_d;
    end

    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed + random bench for hazard_scoreboard against a cycle-arithmetic model.
// Follows SCOREBOARD_FWD_EN the same way the RTL does.
module tb_hazard_scoreboard;

    localparam int NR  = 32;
    localparam int ALU = 1;
    localparam int LD  = 2;
    localparam int WB  = 3;
`ifdef SCOREBOARD_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset_n;
    logic        issue_valid, issue_wr_en, issue_is_load;
    logic [4:0]  issue_rd, src_a, src_b;
    logic        use_a, use_b, flush;
    logic        stall, issue_fire;
    logic [1:0]  fwd_a, fwd_b;
    logic [15:0] stall_cnt;

    always #5 clock = ~clock;

    hazard_scoreboard #(
        .NUM_REGS(NR), .RA_W(5), .ALU_LAT(ALU), .LOAD_LAT(LD),
        .WB_AGE(WB), .STALL_CNT_W(16)
    ) u_dut (
        .clock(clock), .reset_n(reset_n),
        .issue_valid(issue_valid), .issue_wr_en(issue_wr_en),
        .issue_is_load(issue_is_load), .issue_rd(issue_rd),
        .src_a(src_a), .src_b(src_b), .use_a(use_a), .use_b(use_b),
        .flush(flush), .stall(stall), .issue_fire(issue_fire),
        .fwd_a(fwd_a), .fwd_b(fwd_b), .stall_cnt(stall_cnt)
    );

    int checks = 0;
    int passes = 0;
    int fails  = 0;

    // Model: cycle of youngest issue and its latency to forwardable, per reg
    int t = 0;
    int iss [NR];
    int lat [NR];
    int m_cnt = 0;

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        checks++;
        assert (got === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int r = 0; r < NR; r++) begin
            iss[r] = -1000;
            lat[r] = 0;
        end
        m_cnt = 0;
    endtask

    function automatic bit m_haz(int src, bit u);
        return u && src != 0 && t < iss[src] + lat[src];
    endfunction

    function automatic int m_fwd(int src, bit u);
        int age;
        if (!FWD || !u || src == 0) return 0;
        age = t - iss[src];
        return (age < WB) ? age : 0;
    endfunction

    task automatic step(string tag, bit v, bit w, bit ld, int rd,
                        int a, bit ua, int b, bit ub, bit fl,
                        output bit s_o, output int fa_o);
        bit es, ef;
        @(negedge clock);
        issue_valid = v; issue_wr_en = w; issue_is_load = ld;
        issue_rd = 5'(rd); src_a = 5'(a); use_a = ua;
        src_b = 5'(b); use_b = ub; flush = fl;
        #1;
        es = v && !fl && (m_haz(a, ua) || m_haz(b, ub));
        ef = v && !fl && !es;
        chk({tag, ".stall"}, 32'(stall), 32'(es));
        chk({tag, ".fire"}, 32'(issue_fire), 32'(ef));
        chk({tag, ".fwd_a"}, 32'(fwd_a), 32'(m_fwd(a, ua)));
        chk({tag, ".fwd_b"}, 32'(fwd_b), 32'(m_fwd(b, ub)));
        chk({tag, ".cnt"}, 32'(stall_cnt), 32'(m_cnt));
        s_o  = stall;
        fa_o = int'(fwd_a);
        @(posedge clock);
        if (ef && w && rd != 0) begin
            iss[rd] = t;
            lat[rd] = !FWD ? WB : (ld ? LD : ALU);
        end
        if (es && m_cnt != 65535) m_cnt++;
        t++;
    endtask

    // Hold one instruction in ID until it fires; reports stalls seen and fwd_a at fire
    task automatic issue(string tag, bit w, bit ld, int rd,
                         int a, bit ua, int b, bit ub,
                         output int ns, output int fa);
        bit s;
        int f;
        ns = 0;
        fa = -1;
        for (int k = 0; k < 8; k++) begin
            step(tag, 1, w, ld, rd, a, ua, b, ub, 0, s, f);
            if (!s) begin
                fa = f;
                return;
            end
            ns++;
        end
        checks++;
        fails++;
        $error("FAIL %s.timeout: got %0d stalls expected fire", tag, ns);
    endtask

    task automatic idle_cnt(string tag, int exp);
        @(negedge clock);
        issue_valid = 0; use_a = 0; use_b = 0; flush = 0;
        #1;
        chk(tag, 32'(stall_cnt), 32'(exp));
        @(posedge clock);
        t++;
    endtask

    initial begin
        int ns, fa, f;
        bit s, held;
        bit v, w, ld, ua, ub, fl;
        int rd, a, b;

        reset_n = 0;
        issue_valid = 1; issue_wr_en = 1; issue_is_load = 1;
        issue_rd = 5'd2; src_a = 5'd2; src_b = 5'd2;
        use_a = 1; use_b = 1; flush = 0;
        model_reset();
        #1;
        chk("rst.stall", 32'(stall), 0);
        chk("rst.fwd_a", 32'(fwd_a), 0);
        chk("rst.cnt", 32'(stall_cnt), 0);
        repeat (2) begin
            @(posedge clock);
            t++;
        end
        #2 reset_n = 1;

        // load-use
        issue("t3.lw", 1, 1, 2, 0, 0, 0, 0, ns, fa);
        issue("t3.use", 1, 0, 1, 2, 1, 0, 0, ns, fa);
`ifdef SCOREBOARD_FWD_EN
        chk("t3.nstall", 32'(ns), 1);
        chk("t3.fwd", 32'(fa), 2);
        idle_cnt("t3.cnt", 1);
`else
        chk("t3.nstall", 32'(ns), 2);
        chk("t3.fwd", 32'(fa), 0);
        idle_cnt("t3.cnt", 2);
`endif

        // reset mid-stream with a load in flight
        issue("t1.lw", 1, 1, 2, 0, 0, 0, 0, ns, fa);
        @(negedge clock);
        issue_valid = 1; issue_wr_en = 1; issue_is_load = 0;
        issue_rd = 5'd1; src_a = 5'd2; use_a = 1; use_b = 0; flush = 0;
        #2 reset_n = 0;
        #1;
        chk("t1.stall", 32'(stall), 0);
        chk("t1.fwd_a", 32'(fwd_a), 0);
        chk("t1.cnt", 32'(stall_cnt), 0);
        @(posedge clock);
        t++;
        model_reset();
        #2 reset_n = 1;
        issue("t1.use", 1, 0, 1, 2, 1, 0, 0, ns, fa);
        chk("t1.nstall", 32'(ns), 0);

`ifdef SCOREBOARD_FWD_EN
        issue("t2.w1", 1, 0, 1, 0, 0, 0, 0, ns, fa);
        issue("t2.u1", 1, 0, 3, 1, 1, 0, 0, ns, fa);
        chk("t2.u1.nstall", 32'(ns), 0);
        chk("t2.u1.fwd", 32'(fa), 1);
        issue("t2.u2", 1, 0, 4, 1, 1, 0, 0, ns, fa);
        chk("t2.u2.fwd", 32'(fa), 2);
        issue("t2.u3", 1, 0, 5, 1, 1, 0, 0, ns, fa);
        chk("t2.u3.fwd", 32'(fa), 0);
`else
        issue("t6.w1", 1, 0, 1, 0, 0, 0, 0, ns, fa);
        issue("t6.u1", 1, 0, 3, 1, 1, 0, 0, ns, fa);
        chk("t6.nstall", 32'(ns), 2);
        chk("t6.fwd", 32'(fa), 0);
        idle_cnt("t6.cnt", 2);
`endif

        // r0 writes are never tracked
        issue("t4.w0", 1, 0, 0, 0, 0, 0, 0, ns, fa);
        issue("t4.u0", 1, 0, 1, 0, 1, 0, 1, ns, fa);
        chk("t4.nstall", 32'(ns), 0);
        chk("t4.fwd", 32'(fa), 0);

        // flush wins over stall; then newest writer overrides a load
        issue("t5.lw", 1, 1, 2, 0, 0, 0, 0, ns, fa);
        step("t5.flush", 1, 1, 0, 1, 2, 1, 0, 0, 1, s, f);
        chk("t5.flush.stall", 32'(s), 0);
        issue("t5.lw2", 1, 1, 2, 0, 0, 0, 0, ns, fa);
        issue("t5.addi", 1, 0, 2, 0, 0, 0, 0, ns, fa);
        issue("t5.use", 1, 0, 3, 2, 1, 0, 0, ns, fa);
`ifdef SCOREBOARD_FWD_EN
        chk("t5.nstall", 32'(ns), 0);
        chk("t5.fwd", 32'(fa), 1);
`endif

        held = 0;
        v = 0; w = 0; ld = 0; ua = 0; ub = 0; rd = 0; a = 0; b = 0;
        for (int i = 0; i < 400; i++) begin
            if (!held) begin
                v  = ($urandom_range(0, 9) < 8);
                w  = $urandom_range(0, 1);
                ld = ($urandom_range(0, 3) == 0);
                rd = $urandom_range(0, 7);
                a  = $urandom_range(0, 7);
                b  = $urandom_range(0, 7);
                ua = $urandom_range(0, 1);
                ub = $urandom_range(0, 1);
            end
            fl = ($urandom_range(0, 9) == 0);
            step("rnd", v, w, ld, rd, a, ua, b, ub, fl, s, f);
            held = s;
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
